// File: rtl/bcd_display_scan_if.sv
// Bus bundle for the two-digit BCD display scanner: capture inputs in, segment/anode drive and status out.
interface bcd_display_scan_if;
   logic [7:0] x;
   logic       load;
   logic       blank_lz;
   logic [6:0] seg;
   logic [1:0] an;
   logic       err;
   logic       ack;

   modport master (output x, load, blank_lz, input seg, an, err, ack);
   modport slave  (input x, load, blank_lz, output seg, an, err, ack);
endinterface

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed seven-segment driver: latches a BCD word and scans units, gap, tens, gap.
module bcd_display_scan #(
   parameter int unsigned DIV = 4
) (
   input logic             clk,
   input logic             reset_n,
   bcd_display_scan_if.slave bus
);

   localparam int unsigned   CW   = $clog2(DIV + 1);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      SHOW_U = 2'd0,
      GAP_U  = 2'd1,
      SHOW_T = 2'd2,
      GAP_T  = 2'd3
   } scan_state_t;

   scan_state_t   state;
   scan_state_t   state_next;
   logic [CW-1:0] presc;
   logic [7:0]    word;
   logic          started;
   logic [6:0]    seg_next;
   logic [1:0]    an_next;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h79;
      endcase
   endfunction

   // Capture path runs independently of the scan, so a load never disturbs the slot timing.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word    <= 8'h00;
         bus.err <= 1'b0;
         bus.ack <= 1'b0;
      end else begin
         bus.ack <= bus.load;
         if (bus.load) begin
            word    <= bus.x;
            bus.err <= (bus.x[7:4] > 4'd9) | (bus.x[3:0] > 4'd9);
         end
      end
   end

   // The first edge after reset only arms the scan, so the registered 00 drive persists one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= SHOW_U;
         presc   <= '0;
         started <= 1'b0;
      end else begin
         started <= 1'b1;
         state   <= state_next;
         if (state_next != state)
            presc <= '0;
         else if (started && (state == SHOW_U || state == SHOW_T))
            presc <= presc + CW'(1);
      end
   end

   always_comb begin
      state_next = state;
      if (started) begin
         case (state)
            SHOW_U: if (presc == LAST) state_next = GAP_U;
            GAP_U:  state_next = SHOW_T;
            SHOW_T: if (presc == LAST) state_next = GAP_T;
            GAP_T:  state_next = SHOW_U;
         endcase
      end
   end

   always_comb begin
      seg_next = 7'h00;
      an_next  = 2'b00;
      if (started) begin
         case (state)
            SHOW_U: begin
               an_next  = 2'b01;
               seg_next = decode(word[3:0]);
            end
            SHOW_T: begin
               an_next  = 2'b10;
               seg_next = (bus.blank_lz && word[7:4] == 4'd0) ? 7'h00 : decode(word[7:4]);
            end
            GAP_U, GAP_T: begin
               an_next  = 2'b00;
               seg_next = 7'h00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.seg <= 7'h00;
         bus.an  <= 2'b00;
      end else begin
         bus.seg <= seg_next;
         bus.an  <= an_next;
      end
   end

endmodule
